// File: rtl/sop_pkg.sv
// Shared constants for the 4-input sum-of-products scanner.
// Holds the input width, row count, counter width, FSM state encodings and the
// golden truth table / minterm count of the SoP function.
package sop_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned ROWS  = 1 << N_IN;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ROWS-1:0] SOP_TABLE    = 16'h1894;
  localparam int unsigned     SOP_MINTERMS = 5;

endpackage

// File: rtl/sop_func.sv
// Pure combinational evaluator of the 4-input sum-of-products function
//   r = (b&~c&~d) | (~a&c&~(b^d)) | (a&~b&c&d)
// Ports:
//   a_i, b_i, c_i, d_i : function inputs, a is the most significant
//   r_o                : function value
module sop_func (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic r_o
);

  assign r_o = (b_i & ~c_i & ~d_i)
             | (~a_i & c_i & ~(b_i ^ d_i))
             | (a_i & ~b_i & c_i & d_i);

endmodule

// File: rtl/sop_table_scanner.sv
// Walks all 16 input combinations of the SoP function in order, streams each
// row out over a valid/ready handshake and captures the truth table and the
// minterm count.
// Optional feature macro: SOP_FIRST_HIT_EN adds first_idx_o/first_valid_o,
// the index of the first minterm accepted in the current scan.
// Ports:
//   clk_i         : clock, rising edge
//   reset_i       : synchronous active-high reset
//   start_i       : scan request, honoured in IDLE only
//   row_ready_i   : consumer accepts the current row
//   row_valid_o   : row_in_o/row_out_o valid (high throughout SCAN)
//   row_in_o      : current input vector {a,b,c,d}
//   row_out_o     : function value for row_in_o
//   busy_o        : high while scanning
//   done_o        : one-cycle pulse after the last row is accepted
//   table_o       : captured truth table, bit i = f(i)
//   count_o       : number of ones in table_o
//   first_idx_o   : (SOP_FIRST_HIT_EN) first accepted minterm index
//   first_valid_o : (SOP_FIRST_HIT_EN) first_idx_o holds a minterm
module sop_table_scanner
  import sop_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             row_ready_i,
  output logic             row_valid_o,
  output logic [N_IN-1:0]  row_in_o,
  output logic             row_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ROWS-1:0]  table_o,
  output logic [CNT_W-1:0] count_o
`ifdef SOP_FIRST_HIT_EN
  ,
  output logic [N_IN-1:0]  first_idx_o,
  output logic             first_valid_o
`endif
);

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [ROWS-1:0]  table_q, table_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             f_c;
  logic             scan_c;
  logic             hs_c;
`ifdef SOP_FIRST_HIT_EN
  logic [N_IN-1:0]  first_idx_q, first_idx_d;
  logic             first_valid_q, first_valid_d;
`endif

  // Single evaluator, always looking at the current row index.
  sop_func u_func (
    .a_i (idx_q[3]),
    .b_i (idx_q[2]),
    .c_i (idx_q[1]),
    .d_i (idx_q[0]),
    .r_o (f_c)
  );

  assign scan_c = (state_q == ST_SCAN);
  assign hs_c   = scan_c & row_ready_i;

  // Row outputs are decoded from state/index so they hold while ready is low.
  assign row_valid_o = scan_c;
  assign row_in_o    = scan_c ? idx_q : '0;
  assign row_out_o   = scan_c & f_c;
  assign busy_o      = scan_c;
  assign done_o      = (state_q == ST_DONE);
  assign table_o     = table_q;
  assign count_o     = count_q;
`ifdef SOP_FIRST_HIT_EN
  assign first_idx_o   = first_idx_q;
  assign first_valid_o = first_valid_q;
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    count_d = count_q;
`ifdef SOP_FIRST_HIT_EN
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          table_d = '0;
          count_d = '0;
`ifdef SOP_FIRST_HIT_EN
          first_idx_d   = '0;
          first_valid_d = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (hs_c) begin
          table_d[idx_q] = f_c;
          count_d        = count_q + CNT_W'(f_c);
`ifdef SOP_FIRST_HIT_EN
          if (f_c && !first_valid_q) begin
            first_idx_d   = idx_q;
            first_valid_d = 1'b1;
          end
`endif
          // Last row goes to DONE instead of incrementing, so idx never wraps.
          if (idx_q == N_IN'(ROWS - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      table_q <= '0;
      count_q <= '0;
`ifdef SOP_FIRST_HIT_EN
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      count_q <= count_d;
`ifdef SOP_FIRST_HIT_EN
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_sop_table_scanner.sv
// Self-checking bench for sop_table_scanner: expected rows are queued when a
// scan start is driven and popped on every accepted handshake.
module tb_sop_table_scanner;
  import sop_pkg::*;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic             row_ready_i;
  logic             row_valid_o;
  logic [N_IN-1:0]  row_in_o;
  logic             row_out_o;
  logic             busy_o;
  logic             done_o;
  logic [ROWS-1:0]  table_o;
  logic [CNT_W-1:0] count_o;
`ifdef SOP_FIRST_HIT_EN
  logic [N_IN-1:0]  first_idx_o;
  logic             first_valid_o;
`endif

  always #5 clk = ~clk;

  sop_table_scanner dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .row_ready_i (row_ready_i),
    .row_valid_o (row_valid_o),
    .row_in_o    (row_in_o),
    .row_out_o   (row_out_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .table_o     (table_o),
    .count_o     (count_o)
`ifdef SOP_FIRST_HIT_EN
    ,
    .first_idx_o   (first_idx_o),
    .first_valid_o (first_valid_o)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  int         hs_cnt = 0;
  logic [4:0] sb_q[$];
  logic       hit_m = 1'b0;
  logic [3:0] hit_idx_m = 4'd0;

  // Reference function from the documented minterm list.
  function automatic logic model_f(input int i);
    return (i == 2) || (i == 4) || (i == 7) || (i == 11) || (i == 12);
  endfunction

  function automatic logic [15:0] model_table();
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i] = model_f(i);
    return t;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += model_f(i) ? 1 : 0;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_scan();
    for (int i = 0; i < 16; i++) sb_q.push_back({4'(i), model_f(i)});
    hit_m = 1'b0;
  endtask

  // One cycle: drive inputs at the falling edge, then check what the next
  // rising edge will see.
  task automatic tick(input logic rdy, input logic st);
    logic [4:0] e;
    @(negedge clk);
    start_i     = st;
    row_ready_i = rdy;
`ifdef SOP_FIRST_HIT_EN
    chk("first_valid", 32'(first_valid_o), 32'(hit_m));
    if (hit_m) chk("first_idx", 32'(first_idx_o), 32'(hit_idx_m));
`endif
    if (row_valid_o && rdy) begin
      hs_cnt++;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("row_in", 32'(row_in_o), 32'(e[4:1]));
        chk("row_out", 32'(row_out_o), 32'(e[0]));
        if (e[0] && !hit_m) begin
          hit_m     = 1'b1;
          hit_idx_m = e[4:1];
        end
      end
    end
  endtask

  // mode 0: ready tied high; mode 1: ready alternates starting high.
  // extra_start: cycle at which a stray start pulse is driven mid-scan.
  task automatic do_scan(input int mode, input int extra_start);
    int   last;
    int   n_done;
    int   done_cyc;
    logic hold_pend;
    logic [3:0] hold_in;
    logic hold_out;
    logic rdy;
    last      = (mode == 0) ? 16 : 31;
    n_done    = 0;
    done_cyc  = 0;
    hold_pend = 1'b0;
    hold_in   = '0;
    hold_out  = 1'b0;
    hs_cnt    = 0;
    tick(1'b1, 1'b1);
    push_scan();
    for (int cyc = 1; cyc <= last + 3; cyc++) begin
      rdy = (mode == 0) || (cyc % 2 == 1);
      tick(rdy, 1'(cyc == extra_start));
      chk("busy", 32'(busy_o), 32'(cyc <= last));
      if (hold_pend) begin
        chk("hold_in", 32'(row_in_o), 32'(hold_in));
        chk("hold_out", 32'(row_out_o), 32'(hold_out));
      end
      hold_pend = row_valid_o && !rdy;
      hold_in   = row_in_o;
      hold_out  = row_out_o;
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
        chk("table_done", 32'(table_o), 32'(model_table()));
        chk("count_done", 32'(count_o), 32'(model_count()));
      end
    end
    chk("done_cnt", 32'(n_done), 32'd1);
    chk("done_cyc", 32'(done_cyc), 32'(last + 1));
    chk("hs_cnt", 32'(hs_cnt), 32'd16);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("table_hold", 32'(table_o), 32'(model_table()));
    chk("count_hold", 32'(count_o), 32'(model_count()));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(row_valid_o), 32'd0);
    chk({tag, "_row_in"}, 32'(row_in_o), 32'd0);
    chk({tag, "_row_out"}, 32'(row_out_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_table"}, 32'(table_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    int n_done;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    row_ready_i = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_reset_outputs("rst");
    reset_i = 1'b0;
    tick(1'b1, 1'b0);

    // Basic scan, ready tied high.
    do_scan(0, 0);
    // Alternating ready.
    do_scan(1, 0);
    // Stray start mid-scan is ignored.
    do_scan(0, 5);

    // Reset while idx = 7.
    tick(1'b1, 1'b1);
    push_scan();
    for (int cyc = 1; cyc <= 7; cyc++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pre_rst_idx", 32'(row_in_o), 32'd7);
    reset_i = 1'b1;
    sb_q.delete();
    hit_m = 1'b0;
    tick(1'b0, 1'b0);
    check_reset_outputs("midrst");
    reset_i = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick(1'b1, 1'b0);
      if (done_o) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    do_scan(0, 0);

    // Start held high: back-to-back scans 18 cycles apart.
    hs_cnt = 0;
    n_done = 0;
    d1 = 0;
    d2 = 0;
    tick(1'b1, 1'b1);
    push_scan();
    for (int cyc = 1; cyc <= 37; cyc++) begin
      tick(1'b1, 1'(cyc < 36));
      if (cyc == 18) push_scan();
      if (cyc == 19) begin
        chk("b2b_tbl_clr", 32'(table_o), 32'd0);
        chk("b2b_cnt_clr", 32'(count_o), 32'd0);
      end
      chk("b2b_busy", 32'(busy_o), 32'((cyc >= 1 && cyc <= 16) || (cyc >= 19 && cyc <= 34)));
      if (done_o) begin
        n_done++;
        if (n_done == 1) d1 = cyc;
        else d2 = cyc;
      end
    end
    chk("b2b_done_cnt", 32'(n_done), 32'd2);
    chk("b2b_done1", 32'(d1), 32'd17);
    chk("b2b_gap", 32'(d2 - d1), 32'd18);
    chk("b2b_hs", 32'(hs_cnt), 32'd32);
    chk("b2b_table", 32'(table_o), 32'(model_table()));
    chk("b2b_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop_table_scanner.md
Name: sop_table_scanner

Overview:
- Sequential companion to the 4-input sum-of-products evaluator.
- Plays the driver/reader role that the bench played by hand: walks all 16 input combinations {a,b,c,d} in order, evaluates the function, and streams each row out through a valid/ready handshake.
- Captures the full truth table and the minterm count in registers.
- Used for self-check of the SoP function and as a row source for display/compare logic.

Parameters:
- N_IN, 4, number of function inputs. Only 4 is legal, because sop_func is fixed at 4 inputs. Localparam ROWS = 1<<N_IN.
- CNT_W, 5, width of the minterm counter. Must hold the value ROWS.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a scan; sampled in IDLE only
- row_ready  input  1  consumer accepts the current row
- row_valid  output  1  row_in/row_out are valid
- row_in  output  N_IN  current input vector {a,b,c,d}, a = MSB
- row_out  output  1  function value for row_in
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse when a scan completes
- table  output  ROWS  truth table; bit i = f(i)
- count  output  CNT_W  number of minterms (ones in table)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Function evaluated: r = (b&~c&~d) | (~a&c&~(b^d)) | (a&~b&c&d).
- Golden results: minterms 2, 4, 7, 11, 12; table = 16'h1894; count = 5.
- Reset values: state=IDLE, idx=0, row_valid=0, row_in=0, row_out=0, busy=0, done=0, table=0, count=0.
- States: IDLE, SCAN, DONE. Encoding is a 2-bit localparam.
- IDLE:
  - start=1 -> SCAN next cycle.
  - idx<=0, table<=0, count<=0 on that transition.
- SCAN:
  - row_valid=1, row_in=idx, row_out=f(idx), combinationally from idx.
  - On row_valid & row_ready: table[idx]<=row_out; count<=count+row_out.
  - On that same handshake: if idx==ROWS-1 -> DONE, else idx<=idx+1.
  - row_ready=0: idx and outputs hold stable. No skipping, no duplicate capture.
- DONE:
  - done=1 for exactly one cycle, row_valid=0, then -> IDLE unconditionally.
- Start handling:
  - start in SCAN or DONE is ignored; it is not queued.
  - start held high through DONE begins a new scan from IDLE on the following cycle.
- table and count hold their last values in IDLE until the next accepted start.
- idx is N_IN bits wide. The final increment is never performed (transition to DONE instead), so there is no wrap.
- Latency with row_ready tied high: start sampled at cycle 0; rows at cycles 1..16; done at cycle 17; busy high for cycles 1..16.
- reset mid-scan: all registers return to reset values on the next edge. No done pulse. Partial table is discarded.
- reset has priority over start.

Optional Feature:
- Macro: SOP_FIRST_HIT_EN
- Defined:
  - Adds outputs first_idx [N_IN] and first_valid [1], both reset to 0 and cleared on scan start.
  - On the first accepted row with row_out=1 in a scan: first_idx<=row_in, first_valid<=1.
  - Both hold until the next start or reset.
  - A scan with no minterms leaves first_valid=0.
- Undefined: ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header sop_pkg:
  - State localparams ST_IDLE=0, ST_SCAN=1, ST_DONE=2.
  - N_IN default, ROWS.
  - Golden constants SOP_TABLE=16'h1894 and SOP_MINTERMS=5, for benches.
- Sub-module sop_func (output r, input a,b,c,d):
  - Pure combinational evaluator, instantiated once.
  - Driven by idx[3], idx[2], idx[1], idx[0].
- Scanner FSM, counter and capture registers live in sop_table_scanner.

Test Plan:
- Reset, then start pulse with row_ready=1 -> 16 handshakes with row_in 0..15 and row_out 0,0,1,0,1,0,0,1,0,0,0,1,1,0,0,0; done at cycle 17; table=16'h1894; count=5.
- row_ready alternating 1/0 each cycle -> row_in/row_out stable while ready=0; same table/count; done 32 cycles after start.
- reset asserted while idx=7 -> next cycle all outputs at reset values; no done pulse; a new start rescans fully to 16'h1894.
- start pulsed again mid-SCAN -> ignored; exactly 16 handshakes and one done. start held high continuously -> back-to-back scans; table cleared at each scan start, done every 18 cycles.
- Consumer checks every accepted row against the golden table -> zero mismatches; busy=1 exactly during SCAN.
- With SOP_FIRST_HIT_EN: first_valid rises after the row-2 handshake with first_idx=2 and holds through DONE; a restart clears it before the row-2 handshake.
